keypad_distance_entry: RTL and testbench
========================================

// Module: keypad_distance_entry
// PURPOSE
//   Inverse of the distance-to-digits path. Collects decimal keypad digits
//   (tens then units) and converts them to an 8-bit binary alarm threshold
//   distance (1..99). Sits between the keypad scanner and the alarm comparator.
//   pending_value feeds the display digit converter for live echo.
// PARAMETERS
//   TIMEOUT_CYCLES  250_000_000  idle cycles before a partial entry is discarded (>=2)
//   DEFAULT_VALUE   8'd30        threshold loaded at reset (must be 1..99)
// PORTS
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-high
//   key_valid      in   1  one-cycle strobe per key press; each high cycle = one key
//   key_code       in   4  0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC-4'hF invalid
//   value          out  8  committed threshold, binary
//   value_valid    out  1  one-cycle pulse, same cycle value updates
//   pending_value  out  8  in-progress entry, binary (0 when idle)
//   digit_count    out  2  digits held: 0, 1 or 2
//   entry_active   out  1  high in ONE or TWO
//   error          out  1  one-cycle pulse on rejected key
//   timeout        out  1  one-cycle pulse when partial entry is discarded
// BEHAVIOUR
//   Reset: state IDLE, value=DEFAULT_VALUE, pending_value=0, digit_count=0.
//   Reset also clears value_valid, error, timeout and entry_active.
//   All outputs registered. Key sampled at edge N; effect visible after edge N.
//   States (transitions apply only when key_valid=1):
//   - IDLE: digit d -> pending=d, count=1, ONE. ENTER/CLEAR -> no change, no error.
//   - ONE: digit d -> pending=pending*10+d, count=2, TWO.
//     ENTER -> commit. CLEAR -> IDLE, pending=0.
//   - TWO: digit -> error pulse, state/pending unchanged.
//     ENTER -> commit. CLEAR -> IDLE, pending=0.
//   - Invalid code (C-F), any state: error pulse, nothing else changes.
//   - Commit: if pending!=0 then value<=pending and value_valid pulses;
//     if pending==0 (e.g. "0", "00") then error pulse and value is kept.
//     Either way -> IDLE, pending=0, count=0.
//   Arithmetic: pending*10 computed in 8 bits (max 9*10+9=99, no overflow).
//   Timeout counter: cleared on every key_valid and in IDLE.
//   - Increments each cycle in ONE/TWO with key_valid=0.
//   - At TIMEOUT_CYCLES-1 -> timeout pulse, IDLE, pending=0, value kept.
//   - A key in the same cycle as expiry wins: key processed, counter cleared,
//     no timeout pulse.
//   value_valid, error and timeout are mutually exclusive in any cycle.
//   Reset mid-entry discards the partial entry and restores DEFAULT_VALUE.
//   Counter width is $clog2(TIMEOUT_CYCLES); no wrap in ONE/TWO.
// TESTING (bench uses TIMEOUT_CYCLES=16)
//   Reset pulse -> value=30, pending=0, digit_count=0, entry_active=0, no pulses.
//   Keys 4,2,B -> pending 4 then 42, count 1 then 2; after B: value=42,
//     value_valid=1 for exactly one cycle, IDLE.
//   Keys 7,B -> value=7, value_valid pulse. Keys 0,B -> error pulse, value stays 7.
//   Keys 1,2,3 -> error on 3, pending=12; B -> value=12. Key C in IDLE -> error only.
//   Key 5 then idle 16 cycles -> timeout pulse on cycle 16, pending=0, value unchanged.
//     Repeat with key 6 on cycle 16 -> no timeout, pending=56.
//   Keys 9,A -> IDLE, pending=0, value unchanged.
//     Keys 8, assert reset -> value=30, IDLE.

Source files
------------

// File: rtl/keypad_distance_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_distance_entry
// Brief    : Two-digit decimal keypad entry converted to a binary alarm
//            threshold (1..99), with clear, enter and idle-timeout handling.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_distance_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter logic [7:0]  DEFAULT_VALUE  = 8'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] value,
    output logic       value_valid,
    output logic [7:0] pending_value,
    output logic [1:0] digit_count,
    output logic       entry_active,
    output logic       error,
    output logic       timeout
);

    localparam int              c_TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TIMER_MAX = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      c_KEY_CLEAR = 4'hA;
    localparam logic [3:0]      c_KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_value;
    logic            r_value_valid;
    logic [7:0]      r_pending;
    logic [1:0]      r_count;
    logic            r_entry_active;
    logic            r_error;
    logic            r_timeout;
    logic [c_TW-1:0] r_timer;

    logic [7:0] w_times_ten;
    logic [7:0] w_next_pending;
    logic       w_is_digit;
    logic       w_is_invalid;

    // pending*10 as (pending<<3)+(pending<<1); result never exceeds 99
    assign w_times_ten    = {r_pending[4:0], 3'b000} + {r_pending[6:0], 1'b0};
    assign w_next_pending = w_times_ten + {4'b0000, key_code};
    assign w_is_digit     = (key_code <= 4'd9);
    assign w_is_invalid   = (key_code >= 4'hC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_value        <= DEFAULT_VALUE;
            r_value_valid  <= 1'b0;
            r_pending      <= 8'd0;
            r_count        <= 2'd0;
            r_entry_active <= 1'b0;
            r_error        <= 1'b0;
            r_timeout      <= 1'b0;
            r_timer        <= '0;
        end else begin
            r_value_valid <= 1'b0;
            r_error       <= 1'b0;
            r_timeout     <= 1'b0;

            if (key_valid) begin
                // A key always beats a simultaneous timer expiry
                r_timer <= '0;
                if (w_is_invalid) begin
                    r_error <= 1'b1;
                end else if (w_is_digit) begin
                    case (r_state)
                        S_IDLE: begin
                            r_pending      <= {4'b0000, key_code};
                            r_count        <= 2'd1;
                            r_entry_active <= 1'b1;
                            r_state        <= S_ONE;
                        end
                        S_ONE: begin
                            r_pending <= w_next_pending;
                            r_count   <= 2'd2;
                            r_state   <= S_TWO;
                        end
                        S_TWO: begin
                            r_error <= 1'b1;
                        end
                        default: begin
                            r_pending      <= 8'd0;
                            r_count        <= 2'd0;
                            r_entry_active <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    endcase
                end else if (r_state != S_IDLE) begin
                    if (key_code == c_KEY_ENTER) begin
                        // A zero entry ("0" or "00") is not a legal threshold
                        if (r_pending != 8'd0) begin
                            r_value       <= r_pending;
                            r_value_valid <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    r_pending      <= 8'd0;
                    r_count        <= 2'd0;
                    r_entry_active <= 1'b0;
                    r_state        <= S_IDLE;
                end else if (key_code != c_KEY_CLEAR) begin
                    r_state <= S_IDLE;
                end
            end else if (r_state != S_IDLE) begin
                if (r_timer == c_TIMER_MAX) begin
                    r_timeout      <= 1'b1;
                    r_timer        <= '0;
                    r_pending      <= 8'd0;
                    r_count        <= 2'd0;
                    r_entry_active <= 1'b0;
                    r_state        <= S_IDLE;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign value         = r_value;
    assign value_valid   = r_value_valid;
    assign pending_value = r_pending;
    assign digit_count   = r_count;
    assign entry_active  = r_entry_active;
    assign error         = r_error;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_keypad_distance_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_distance_entry
// Brief    : Directed scenarios plus randomized keys against a digit-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_distance_entry;

    localparam int c_TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] value;
    logic       value_valid;
    logic [7:0] pending_value;
    logic [1:0] digit_count;
    logic       entry_active;
    logic       error;
    logic       timeout;

    int n_cmp;
    int n_bad;

    // Reference model: list of entered digits, committed value, pulses
    int m_digits[$];
    int m_value;
    int m_idle;
    bit m_vv;
    bit m_err;
    bit m_to;

    keypad_distance_entry #(
        .TIMEOUT_CYCLES(c_TIMEOUT),
        .DEFAULT_VALUE (8'd30)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .value        (value),
        .value_valid  (value_valid),
        .pending_value(pending_value),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .error        (error),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pending();
        int p;
        p = 0;
        foreach (m_digits[i]) p = p * 10 + m_digits[i];
        return p;
    endfunction

    function automatic void model_reset();
        m_digits.delete();
        m_value = 30;
        m_idle  = 0;
        m_vv    = 0;
        m_err   = 0;
        m_to    = 0;
    endfunction

    function automatic void model_step(input bit kv, input int code);
        m_vv  = 0;
        m_err = 0;
        m_to  = 0;
        if (kv) begin
            m_idle = 0;
            if (code >= 12) begin
                m_err = 1;
            end else if (code <= 9) begin
                if (m_digits.size() < 2) m_digits.push_back(code);
                else m_err = 1;
            end else if (m_digits.size() > 0) begin
                if (code == 11) begin
                    if (model_pending() != 0) begin
                        m_value = model_pending();
                        m_vv    = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                m_digits.delete();
            end
        end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == c_TIMEOUT) begin
                m_to = 1;
                m_idle = 0;
                m_digits.delete();
            end
        end else begin
            m_idle = 0;
        end
    endfunction

    task automatic step(input bit kv, input logic [3:0] code);
        @(negedge clk);
        key_valid = kv;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_step(kv, int'(code));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({value, pending_value, digit_count, entry_active, value_valid, error, timeout}
            !== {8'd30, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got value=%0d pend=%0d cnt=%0d act=%b vv=%b err=%b to=%b, expected 30/0/0/0/0/0/0",
                     value, pending_value, digit_count, entry_active, value_valid, error, timeout);
        end
    endtask

    task automatic test_two_digit_commit();
        step(1'b1, 4'd4);
        n_cmp++;
        if ({pending_value, digit_count, entry_active} !== {8'd4, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL first_digit: got pend=%0d cnt=%0d act=%b, expected 4/1/1", pending_value, digit_count, entry_active);
        end
        step(1'b1, 4'd2);
        n_cmp++;
        if ({pending_value, digit_count} !== {8'd42, 2'd2}) begin
            n_bad++;
            $display("FAIL second_digit: got pend=%0d cnt=%0d, expected 42/2", pending_value, digit_count);
        end
        step(1'b1, 4'hB);
        n_cmp++;
        if ({value, value_valid, pending_value, digit_count, entry_active, error}
            !== {8'd42, 1'b1, 8'd0, 2'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL commit_42: got value=%0d vv=%b pend=%0d cnt=%0d act=%b err=%b, expected 42/1/0/0/0/0",
                     value, value_valid, pending_value, digit_count, entry_active, error);
        end
        step(1'b0, 4'h0);
        n_cmp++;
        if ({value, value_valid} !== {8'd42, 1'b0}) begin
            n_bad++;
            $display("FAIL valid_one_cycle: got value=%0d vv=%b, expected 42/0", value, value_valid);
        end
    endtask

    task automatic test_single_and_zero();
        step(1'b1, 4'd7);
        step(1'b1, 4'hB);
        n_cmp++;
        if ({value, value_valid, error} !== {8'd7, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL commit_7: got value=%0d vv=%b err=%b, expected 7/1/0", value, value_valid, error);
        end
        step(1'b1, 4'd0);
        step(1'b1, 4'hB);
        n_cmp++;
        if ({value, value_valid, error, entry_active} !== {8'd7, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_entry: got value=%0d vv=%b err=%b act=%b, expected 7/0/1/0", value, value_valid, error, entry_active);
        end
    endtask

    task automatic test_third_digit_and_invalid();
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        n_cmp++;
        if ({error, pending_value, digit_count} !== {1'b1, 8'd12, 2'd2}) begin
            n_bad++;
            $display("FAIL third_digit: got err=%b pend=%0d cnt=%0d, expected 1/12/2", error, pending_value, digit_count);
        end
        step(1'b1, 4'hB);
        n_cmp++;
        if ({value, value_valid} !== {8'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL commit_12: got value=%0d vv=%b, expected 12/1", value, value_valid);
        end
        step(1'b1, 4'hC);
        n_cmp++;
        if ({error, value, value_valid, pending_value, entry_active, timeout}
            !== {1'b1, 8'd12, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL invalid_idle: got err=%b value=%0d vv=%b pend=%0d act=%b to=%b, expected 1/12/0/0/0/0",
                     error, value, value_valid, pending_value, entry_active, timeout);
        end
    endtask

    task automatic test_timeout();
        bit early;
        early = 0;
        step(1'b1, 4'd5);
        for (int i = 1; i < c_TIMEOUT; i++) begin
            step(1'b0, 4'h0);
            if (timeout !== 1'b0 || pending_value !== 8'd5) early = 1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL timeout_early: got to=%b pend=%0d before idle cycle 16, expected 0/5", timeout, pending_value);
        end
        step(1'b0, 4'h0);
        n_cmp++;
        if ({timeout, pending_value, digit_count, entry_active, value, error}
            !== {1'b1, 8'd0, 2'd0, 1'b0, 8'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_expiry: got to=%b pend=%0d cnt=%0d act=%b value=%0d err=%b, expected 1/0/0/0/12/0",
                     timeout, pending_value, digit_count, entry_active, value, error);
        end
        step(1'b0, 4'h0);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_one_cycle: got to=%b, expected 0", timeout);
        end
    endtask

    task automatic test_key_at_expiry();
        step(1'b1, 4'd5);
        for (int i = 1; i < c_TIMEOUT; i++) step(1'b0, 4'h0);
        step(1'b1, 4'd6);
        n_cmp++;
        if ({timeout, error, pending_value, digit_count, entry_active}
            !== {1'b0, 1'b0, 8'd56, 2'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL key_at_expiry: got to=%b err=%b pend=%0d cnt=%0d act=%b, expected 0/0/56/2/1",
                     timeout, error, pending_value, digit_count, entry_active);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 4'hA);
        step(1'b1, 4'd9);
        step(1'b1, 4'hA);
        n_cmp++;
        if ({pending_value, digit_count, entry_active, value, value_valid, error}
            !== {8'd0, 2'd0, 1'b0, 8'd12, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clear: got pend=%0d cnt=%0d act=%b value=%0d vv=%b err=%b, expected 0/0/0/12/0/0",
                     pending_value, digit_count, entry_active, value, value_valid, error);
        end
    endtask

    task automatic test_reset_mid_entry();
        step(1'b1, 4'd8);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({value, pending_value, digit_count, entry_active} !== {8'd30, 8'd0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_entry: got value=%0d pend=%0d cnt=%0d act=%b, expected 30/0/0/0",
                     value, pending_value, digit_count, entry_active);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int errs;
        int excl;
        logic [3:0] code;
        bit kv;
        errs = 0;
        excl = 0;
        for (int i = 0; i < 1200; i++) begin
            // Alternate busy and sparse phases so timeouts also occur
            if (((i / 60) % 2) == 0) kv = ($urandom_range(0, 2) == 0);
            else kv = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 9))
                0:       code = 4'hA;
                1, 2:    code = 4'hB;
                3:       code = 4'($urandom_range(12, 15));
                default: code = 4'($urandom_range(0, 9));
            endcase
            step(kv, code);
            n_cmp++;
            if ({value, value_valid, pending_value, digit_count, entry_active, error, timeout}
                !== {8'(m_value), m_vv, 8'(model_pending()), 2'(m_digits.size()),
                     (m_digits.size() != 0), m_err, m_to}) begin
                n_bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random_cycle_%0d: got value=%0d vv=%b pend=%0d cnt=%0d act=%b err=%b to=%b, expected %0d/%b/%0d/%0d/%b/%b/%b",
                             i, value, value_valid, pending_value, digit_count, entry_active, error, timeout,
                             m_value, m_vv, model_pending(), m_digits.size(), (m_digits.size() != 0), m_err, m_to);
            end
            if (32'(value_valid) + 32'(error) + 32'(timeout) > 1) excl++;
        end
        n_cmp++;
        if (excl != 0) begin
            n_bad++;
            $display("FAIL pulse_exclusive: got %0d cycles with overlapping pulses, expected 0", excl);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        test_reset();
        test_two_digit_commit();
        test_single_and_zero();
        test_third_digit_and_invalid();
        test_timeout();
        test_key_at_expiry();
        test_clear();
        test_reset_mid_entry();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
